// File: rtl/template_match_ctrl_pkg.sv
// Shared definitions for the template-match controller and the matcher:
// wave classification codes, derivative offset and controller FSM states.
package template_match_ctrl_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI = 2'd0,
        WAVE_SQR = 2'd1,
        WAVE_SIN = 2'd2
    } wave_type_e;

    // A flat signal has m_dwave sitting at this value.
    localparam logic [7:0] DWAVE_OFFSET = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/template_match_ctrl_if.sv
// Bundle of the controller's host, sample-buffer and matcher signals.
// The slave modport is the controller; the master modport is its environment.
interface template_match_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              m_valid;
    logic [7:0]        m_wave;
    logic [7:0]        m_dwave;
    logic [1:0]        m_type;
    logic              busy;
    logic              type_valid;
    logic [1:0]        wave_type;

    modport master (
        output start, abort, rd_data, m_type,
        input  rd_addr, m_valid, m_wave, m_dwave, busy, type_valid, wave_type
    );

    modport slave (
        input  start, abort, rd_data, m_type,
        output rd_addr, m_valid, m_wave, m_dwave, busy, type_valid, wave_type
    );
endinterface

// File: rtl/template_match_ctrl_wave_diff.sv
// First difference of the sample stream, re-centred on the offset and
// clamped to an unsigned byte. History advances only on accepted samples.
module wave_diff
    import template_match_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] sample,
    input  logic       first,
    output logic [7:0] dwave
);

    logic        [7:0] prev_p0;
    logic signed [9:0] diff;

    function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > 10'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    always_comb begin
        diff  = $signed({2'b00, sample}) - $signed({2'b00, prev_p0})
              + $signed({2'b00, DWAVE_OFFSET});
        dwave = first ? DWAVE_OFFSET : sat_u8(diff);
    end

    // stage p0: previous accepted sample
    always_ff @(posedge clk) begin
        if (rst)
            prev_p0 <= '0;
        else if (en)
            prev_p0 <= sample;
    end

endmodule

// File: rtl/template_match_ctrl.sv
// Frame sequencer: walks the sample buffer and templates with one shared
// address, streams wave/derivative to the matcher, then latches its verdict.
module template_match_ctrl
    import template_match_ctrl_pkg::*;
#(
    parameter int N_SAMPLES  = 256,
    parameter int ADDR_W     = 8,
    parameter int LAT_RESULT = 2
) (
    input logic                 clk,
    input logic                 rst,
    template_match_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W:0]   CNT_END    = (ADDR_W + 1)'(N_SAMPLES);
    localparam logic [7:0]        DRAIN_LAST = 8'(LAT_RESULT - 1);

    state_e            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        drain_cnt;
    logic              m_valid;
    logic [7:0]        m_wave;
    logic [7:0]        m_dwave;
    logic              busy;
    logic              type_valid;
    logic [1:0]        wave_type;
    logic [7:0]        dwave_nxt;
    logic              diff_en;
    logic              diff_first;

    // rd_data in RUN belongs to sample cnt; cnt == N_SAMPLES is the pipeline tail.
    assign diff_en    = (state == ST_RUN) && (cnt != CNT_END);
    assign diff_first = (cnt == '0);

    wave_diff u_wave_diff (
        .clk    (clk),
        .rst    (rst),
        .en     (diff_en),
        .sample (bus.rd_data),
        .first  (diff_first),
        .dwave  (dwave_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_addr    <= '0;
            cnt        <= '0;
            drain_cnt  <= '0;
            m_valid    <= 1'b0;
            m_wave     <= '0;
            m_dwave    <= DWAVE_OFFSET;
            busy       <= 1'b0;
            type_valid <= 1'b0;
            wave_type  <= WAVE_TRI;
        end else if (bus.abort && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            rd_addr    <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            type_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_addr    <= '0;
                    m_valid    <= 1'b0;
                    type_valid <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state <= ST_PRIME;
                        busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    rd_addr <= rd_addr + 1'b1;
                    cnt     <= '0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt != CNT_END) begin
                        if (rd_addr != ADDR_LAST)
                            rd_addr <= rd_addr + 1'b1;
                        m_valid <= 1'b1;
                        m_wave  <= bus.rd_data;
                        m_dwave <= dwave_nxt;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        rd_addr   <= '0;
                        m_valid   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        wave_type  <= bus.m_type;
                        type_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    type_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_addr    = rd_addr;
    assign bus.m_valid    = m_valid;
    assign bus.m_wave     = m_wave;
    assign bus.m_dwave    = m_dwave;
    assign bus.busy       = busy;
    assign bus.type_valid = type_valid;
    assign bus.wave_type  = wave_type;

endmodule

// File: tb/tb_template_match_ctrl.sv
// Directed bench for template_match_ctrl: buffer model, matcher verdict driver,
// stream monitor, table of derivative vectors and hand-written corner sequences.
module tb_template_match_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    template_match_ctrl_if #(.ADDR_W(8)) bus ();

    template_match_ctrl #(
        .N_SAMPLES  (256),
        .ADDR_W     (8),
        .LAT_RESULT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];

    // Sample buffer: one-cycle read latency.
    always_ff @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Stream monitor
    int         cap_idx;
    int         first_v_cyc;
    int         last_v_cyc;
    int         tv_count;
    int         tv_cyc;
    logic [7:0] cap_wave  [1024];
    logic [7:0] cap_dwave [1024];

    initial begin
        cap_idx  = 0;
        tv_count = 0;
        forever begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) begin
                if (cap_idx == 0) first_v_cyc = cyc;
                if (cap_idx < 1024) begin
                    cap_wave[cap_idx]  = bus.m_wave;
                    cap_dwave[cap_idx] = bus.m_dwave;
                end
                cap_idx++;
                last_v_cyc = cyc;
            end
            if (bus.type_valid === 1'b1) begin
                tv_count++;
                tv_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        cap_idx  = 0;
        tv_count = 0;
    endtask

    int start_cyc;

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_cap(input string name, input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cap_idx < target && n < budget);
        if (cap_idx < target) chk({name, "_timeout"}, 32'(cap_idx), 32'(target));
    endtask

    // Count ramp-frame beats whose wave or derivative deviate from the ramp.
    task automatic ramp_errs(output int bad_w, output int bad_d);
        bad_w = 0;
        bad_d = 0;
        for (int i = 0; i < 256; i++) begin
            if (cap_wave[i] !== 8'(i)) bad_w++;
            if (cap_dwave[i] !== ((i == 0) ? 8'd128 : 8'd129)) bad_d++;
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vt [12];

    initial begin
        int bad_w;
        int bad_d;
        int n;

        vt[0]  = '{8'd0,   8'd128};  // first sample of frame
        vt[1]  = '{8'd255, 8'd255};  // 383 clamps high
        vt[2]  = '{8'd0,   8'd0};    // -127 clamps low
        vt[3]  = '{8'd255, 8'd255};
        vt[4]  = '{8'd100, 8'd0};    // -27 clamps low
        vt[5]  = '{8'd90,  8'd118};
        vt[6]  = '{8'd90,  8'd128};
        vt[7]  = '{8'd217, 8'd255};  // exactly 255
        vt[8]  = '{8'd90,  8'd1};
        vt[9]  = '{8'd218, 8'd255};  // 256 clamps
        vt[10] = '{8'd89,  8'd0};    // -1 clamps
        vt[11] = '{8'd89,  8'd128};

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.m_type = 2'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_wave", 32'(bus.m_wave), 32'd0);
        chk("rst_m_dwave", 32'(bus.m_dwave), 32'd128);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_type_valid", 32'(bus.type_valid), 32'd0);
        chk("rst_wave_type", 32'(bus.wave_type), 32'd0);

        // Ramp frame: timing, order and constant derivative
        bus.m_type = 2'd1;
        mon_clear();
        pulse_start();
        wait_idle("ramp", 400);
        chk("ramp_beats", 32'(cap_idx), 32'd256);
        chk("ramp_first_lat", 32'(first_v_cyc - start_cyc), 32'd3);
        chk("ramp_contig", 32'(last_v_cyc - first_v_cyc), 32'd255);
        chk("ramp_tv_lat", 32'(tv_cyc - start_cyc), 32'd261);
        chk("ramp_tv_count", 32'(tv_count), 32'd1);
        chk("ramp_wave_type", 32'(bus.wave_type), 32'd1);
        ramp_errs(bad_w, bad_d);
        chk("ramp_wave_errs", 32'(bad_w), 32'd0);
        chk("ramp_dwave_errs", 32'(bad_d), 32'd0);
        chk("ramp_hold_wave", 32'(bus.m_wave), 32'd255);
        chk("ramp_hold_dwave", 32'(bus.m_dwave), 32'd129);

        // Table frame: derivative saturation, ignored restarts while busy and in DONE
        for (int i = 0; i < 256; i++) mem[i] = (i < 12) ? vt[i].x : 8'd89;
        bus.m_type = 2'd2;
        mon_clear();
        pulse_start();
        repeat (50) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.type_valid !== 1'b1 && n < 400);
        if (bus.type_valid !== 1'b1) chk("tbl_tv_timeout", 32'd0, 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("done_start_busy", 32'(bus.busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("tbl_busy_after", 32'(bus.busy), 32'd0);
        chk("tbl_beats", 32'(cap_idx), 32'd256);
        chk("tbl_tv_count", 32'(tv_count), 32'd1);
        chk("tbl_wave_type", 32'(bus.wave_type), 32'd2);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl_wave_%0d", i), 32'(cap_wave[i]), 32'(vt[i].x));
            chk($sformatf("tbl_dwave_%0d", i), 32'(cap_dwave[i]), 32'(vt[i].exp_d));
        end
        bad_d = 0;
        for (int i = 12; i < 256; i++) if (cap_dwave[i] !== 8'd128) bad_d++;
        chk("tbl_tail_dwave_errs", 32'(bad_d), 32'd0);

        // Abort mid-frame, then a clean restart from address 0
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        bus.m_type = 2'd0;
        mon_clear();
        pulse_start();
        wait_cap("abort", 100, 400);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (300) @(negedge clk);
        chk("abort_tv_count", 32'(tv_count), 32'd0);
        chk("abort_wave_type", 32'(bus.wave_type), 32'd2);
        chk("abort_beats", 32'(cap_idx), 32'd101);
        chk("abort_hold_wave", 32'(bus.m_wave), 32'd100);
        chk("abort_hold_dwave", 32'(bus.m_dwave), 32'd129);

        bus.m_type = 2'd1;
        mon_clear();
        pulse_start();
        wait_idle("restart", 400);
        chk("restart_beats", 32'(cap_idx), 32'd256);
        ramp_errs(bad_w, bad_d);
        chk("restart_wave_errs", 32'(bad_w), 32'd0);
        chk("restart_dwave_errs", 32'(bad_d), 32'd0);
        chk("restart_tv_count", 32'(tv_count), 32'd1);
        chk("restart_wave_type", 32'(bus.wave_type), 32'd1);

        // Reset during the first DRAIN cycle
        bus.m_type = 2'd2;
        mon_clear();
        pulse_start();
        wait_cap("drain_rst", 256, 400);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("drst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("drst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("drst_m_wave", 32'(bus.m_wave), 32'd0);
        chk("drst_m_dwave", 32'(bus.m_dwave), 32'd128);
        chk("drst_busy", 32'(bus.busy), 32'd0);
        chk("drst_type_valid", 32'(bus.type_valid), 32'd0);
        chk("drst_wave_type", 32'(bus.wave_type), 32'd0);
        repeat (10) @(negedge clk);
        chk("drst_tv_count", 32'(tv_count), 32'd0);

        // start and abort together in IDLE
        mon_clear();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("sa_beats", 32'(cap_idx), 32'd0);
        chk("sa_tv_count", 32'(tv_count), 32'd0);
        chk("sa_busy_late", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
